fuel_ctrl: RTL and testbench

- Game-round controller that owns the fuel tank. It sequences the round (idle, run, pause, empty) and arbitrates every request that changes fuel.
- Fuel change sources: the periodic drain tick, pickup refuels (queued and applied gradually), and crash penalties.
- Drives the HUD fuel bar width, low-fuel warning/blink and the round time-out flag consumed by the top-level game FSM.

---
 rtl/fuel_pkg.sv | 27 ++
 rtl/fuel_ctrl_tick_prescaler.sv | 36 +++
 rtl/fuel_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fuel_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fuel_pkg.sv
// Shared types and helpers for the fuel controller: round-state encoding,
// the fuel width and a saturating clamp for the signed fuel-update sum.
package fuel_pkg;

    localparam int FUEL_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_EMPTY  = 2'd3
    } state_t;

    function automatic logic [FUEL_W-1:0] clamp_fuel(
        input logic signed [8:0]   v,
        input logic [FUEL_W-1:0]   max_v
    );
        if (v < 0) begin
            return '0;
        end else if (v > $signed({2'b00, max_v})) begin
            return max_v;
        end else begin
            return v[FUEL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fuel_ctrl_tick_prescaler.sv
// Free-running 0..TICKS-1 counter: wrap pulses high for the one cycle the
// counter sits at TICKS-1 while enabled. clr wins over en and parks it at 0.
module tick_prescaler #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        wrap  = en && !clr && (cnt_q == CW'(TICKS - 1));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fuel_ctrl.sv
// Round controller owning the fuel tank: sequences IDLE/RUN/PAUSED/EMPTY and
// merges drain, gradual refuel and crash penalties into one update per cycle.
module fuel_ctrl
    import fuel_pkg::*;
#(
    parameter int unsigned FUEL_MAX          = 96,
    parameter int unsigned DRAIN_TICKS       = 12500000,
    parameter int unsigned REFUEL_AMT        = 24,
    parameter int unsigned REFUEL_STEP_TICKS = 1250000,
    parameter int unsigned CRASH_PENALTY     = 8,
    parameter int unsigned LOW_THRESH        = 24,
    parameter int unsigned BLINK_TICKS       = 12500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause_tgl,
    input  logic              pickup,
    input  logic              crash,
    output logic [FUEL_W-1:0] fuel_width,
    output logic              low_fuel,
    output logic              warn_blink,
    output logic              time_out,
    output logic [1:0]        state,
    output logic              refuel_busy
);

    localparam logic [FUEL_W-1:0] FMAX = FUEL_W'(FUEL_MAX);
    localparam logic [FUEL_W-1:0] FLOW = FUEL_W'(LOW_THRESH);

    state_t            state_q, state_d;
    logic [FUEL_W-1:0] fuel_q, fuel_d;
    logic [FUEL_W-1:0] pend_q, pend_d;
    logic              low_q, low_d;
    logic              blink_q, blink_d;
    logic              to_q, to_d;

    logic              run;
    logic              reload;
    logic              drain_ev, step_ev, blink_ev;
    logic signed [8:0] sum;
    logic [FUEL_W-1:0] fuel_next;
    logic [7:0]        pend_add, room;
    logic [FUEL_W-1:0] pend_pick;

    assign run    = (state_q == ST_RUN);
    assign reload = start && ((state_q == ST_IDLE) || (state_q == ST_EMPTY));

    tick_prescaler #(.TICKS(DRAIN_TICKS)) u_drain (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clr   (reload),
        .wrap  (drain_ev)
    );

    // Refuel timer only advances while something is queued; parked at 0 otherwise.
    tick_prescaler #(.TICKS(REFUEL_STEP_TICKS)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run && (pend_q != '0)),
        .clr   (reload || (pend_q == '0)),
        .wrap  (step_ev)
    );

    tick_prescaler #(.TICKS(BLINK_TICKS)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run && low_q),
        .clr   (reload || !low_q),
        .wrap  (blink_ev)
    );

    always_comb begin
        sum       = 9'(fuel_q) + 9'(step_ev) - 9'(drain_ev)
                  - (crash ? 9'(CRASH_PENALTY) : 9'd0);
        fuel_next = clamp_fuel(sum, FMAX);
        pend_add  = 8'(pend_q) + 8'(REFUEL_AMT);
        room      = 8'(FMAX) - 8'(fuel_q);
        pend_pick = (pend_add < room) ? pend_add[FUEL_W-1:0] : room[FUEL_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (fuel_next == '0) begin
                    state_d = ST_EMPTY;
                end else if (pause_tgl) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: if (pause_tgl) state_d = ST_RUN;
            ST_EMPTY:  if (start) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fuel_d = fuel_q;
        pend_d = pend_q;
        case (state_q)
            ST_IDLE, ST_EMPTY: begin
                if (start) begin
                    fuel_d = FMAX;
                    pend_d = '0;
                end
            end
            ST_RUN: begin
                fuel_d = fuel_next;
                pend_d = pickup ? pend_pick : pend_q;
                if (step_ev && (pend_d != '0)) begin
                    pend_d = pend_d - 1'b1;
                end
                // Empty tank ends the round; a full tank discards any excess.
                if ((fuel_next == '0) || (fuel_next == FMAX)) begin
                    pend_d = '0;
                end
            end
            default: ;
        endcase

        low_d   = (fuel_q <= FLOW) && (state_q != ST_IDLE);
        blink_d = low_d ? (blink_ev ? !blink_q : blink_q) : 1'b0;
        to_d    = (state_d == ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fuel_q  <= FMAX;
            pend_q  <= '0;
            low_q   <= 1'b0;
            blink_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            fuel_q  <= fuel_d;
            pend_q  <= pend_d;
            low_q   <= low_d;
            blink_q <= blink_d;
            to_q    <= to_d;
        end
    end

    assign fuel_width  = fuel_q;
    assign low_fuel    = low_q;
    assign warn_blink  = blink_q;
    assign time_out    = to_q;
    assign state       = state_q;
    assign refuel_busy = (pend_q != '0);

endmodule

// File: tb/tb_fuel_ctrl.sv
// Directed bench for fuel_ctrl with shrunken timing parameters: a vector
// table for round sequencing plus hand sequences for blink and async reset.
module tb_fuel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause_tgl, pickup, crash;
    logic [6:0] fuel_width;
    logic       low_fuel, warn_blink, time_out, refuel_busy;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fuel_ctrl #(
        .FUEL_MAX          (16),
        .DRAIN_TICKS       (4),
        .REFUEL_AMT        (6),
        .REFUEL_STEP_TICKS (2),
        .CRASH_PENALTY     (5),
        .LOW_THRESH        (4),
        .BLINK_TICKS       (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause_tgl   (pause_tgl),
        .pickup      (pickup),
        .crash       (crash),
        .fuel_width  (fuel_width),
        .low_fuel    (low_fuel),
        .warn_blink  (warn_blink),
        .time_out    (time_out),
        .state       (state),
        .refuel_busy (refuel_busy)
    );

    // n = extra idle cycles after the pulse cycle before outputs are compared.
    typedef struct {
        logic st, pt, pk, cr;
        int   n;
        int   fuel;
        int   stt;
        logic to, busy, low;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, pt, pk, cr, input int n, fu, s,
                       input logic to, bz, lo);
        vec_t v;
        v = '{st, pt, pk, cr, n, fu, s, to, bz, lo};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".fuel"},  int'(fuel_width), 16);
        chk({tag, ".state"}, int'(state), 0);
        chk({tag, ".to"},    int'(time_out), 0);
        chk({tag, ".blink"}, int'(warn_blink), 0);
        chk({tag, ".low"},   int'(low_fuel), 0);
        chk({tag, ".busy"},  int'(refuel_busy), 0);
    endtask

    task automatic pulse(input logic st, pt, pk, cr);
        start = st; pause_tgl = pt; pickup = pk; crash = cr;
        @(negedge clk);
        start = 1'b0; pause_tgl = 1'b0; pickup = 1'b0; crash = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0; pause_tgl = 1'b0; pickup = 1'b0; crash = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk_reset("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst1");

        //  st pt pk cr   n  fuel st  to bz lo
        add(1, 0, 0, 0,  0, 16, 1, 0, 0, 0);  // start
        add(0, 0, 1, 0,  0, 16, 1, 0, 0, 0);  // pickup on full tank queues nothing
        add(0, 0, 0, 0,  1, 16, 1, 0, 0, 0);
        add(0, 0, 0, 0,  0, 15, 1, 0, 0, 0);  // first drain after 4 RUN cycles
        add(0, 0, 1, 0,  0, 15, 1, 0, 1, 0);  // pending clamped to 1
        add(0, 0, 0, 0,  1, 16, 1, 0, 0, 0);  // step tops up to max
        add(0, 0, 0, 0,  0, 15, 1, 0, 0, 0);
        add(0, 0, 0, 0, 19, 10, 1, 0, 0, 0);
        add(0, 0, 1, 0,  0, 10, 1, 0, 1, 0);  // pending = 6
        add(0, 0, 0, 0, 10, 12, 1, 0, 1, 0);
        add(0, 0, 0, 0,  0, 13, 1, 0, 0, 0);  // last step, busy falls
        add(0, 0, 0, 0, 14,  9, 1, 0, 0, 0);
        add(0, 1, 0, 0,  0,  9, 2, 0, 0, 0);  // pause
        add(0, 0, 1, 0, 99,  9, 2, 0, 0, 0);  // frozen, pickup ignored
        add(0, 0, 0, 1,  0,  9, 2, 0, 0, 0);  // crash ignored
        add(1, 0, 0, 0,  0,  9, 2, 0, 0, 0);  // start ignored
        add(0, 1, 0, 0,  0,  9, 1, 0, 0, 0);  // resume
        add(0, 0, 0, 0,  1,  9, 1, 0, 0, 0);
        add(0, 0, 0, 0,  0,  8, 1, 0, 0, 0);  // drain resumes from frozen count
        add(0, 0, 0, 0, 19,  3, 1, 0, 0, 1);
        add(0, 0, 1, 1,  0,  0, 3, 1, 0, 1);  // crash empties, pending cleared
        add(0, 0, 1, 0,  3,  0, 3, 1, 0, 1);
        add(0, 1, 0, 0,  0,  0, 3, 1, 0, 1);
        add(1, 0, 0, 0,  0, 16, 1, 0, 0, 1);  // restart from EMPTY
        add(0, 0, 0, 0,  0, 16, 1, 0, 0, 0);
        add(0, 0, 0, 0, 61,  1, 1, 0, 0, 1);
        add(0, 0, 0, 0,  0,  0, 3, 1, 0, 1);  // empty at RUN cycle 64
        add(1, 0, 0, 0,  0, 16, 1, 0, 0, 1);
        add(0, 0, 1, 1,  0, 11, 1, 0, 0, 0);  // pickup headroom taken before crash
        add(0, 0, 1, 0,  0, 11, 1, 0, 1, 0);

        foreach (vq[i]) begin
            pulse(vq[i].st, vq[i].pt, vq[i].pk, vq[i].cr);
            repeat (vq[i].n) @(negedge clk);
            chk($sformatf("v%0d.fuel", i),  int'(fuel_width),  vq[i].fuel);
            chk($sformatf("v%0d.state", i), int'(state),       vq[i].stt);
            chk($sformatf("v%0d.to", i),    int'(time_out),    int'(vq[i].to));
            chk($sformatf("v%0d.busy", i),  int'(refuel_busy), int'(vq[i].busy));
            chk($sformatf("v%0d.low", i),   int'(low_fuel),    int'(vq[i].low));
        end

        // Low-fuel blink: two crashes take fuel to 6, drain brings it to 4.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 0, 1);
        chk("blk.fuel2", int'(fuel_width), 6);
        for (int i = 3; i <= 20; i++) begin
            @(negedge clk);
            chk($sformatf("blk%0d.fuel", i),  int'(fuel_width), 6 - i / 4);
            chk($sformatf("blk%0d.low", i),   int'(low_fuel),   (i >= 9) ? 1 : 0);
            chk($sformatf("blk%0d.blink", i), int'(warn_blink),
                ((i >= 12) && ((((i - 12) / 3) % 2) == 0)) ? 1 : 0);
        end

        // Asynchronous reset mid-round, away from any clock edge.
        #1 rst_n = 1'b0;
        #1 chk_reset("rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
